// File: rtl/t06_lcd_refresh_ctrl.sv
// HD44780 16x2 refresh controller: power-up wait, init command sequence, then continuous
// two-row streaming. Build macro T06_LCD_SKIP_SAME_EN suppresses resending unchanged frames.
`timescale 1ns/1ps
module t06_lcd_refresh_ctrl #(
  parameter int unsigned POWERUP_CYC = 4000000,
  parameter int unsigned E_PULSE_CYC = 20,
  parameter int unsigned CMD_CYC     = 2000,
  parameter int unsigned CLEAR_CYC   = 80000
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         en,
  input  logic [127:0] row_top,
  input  logic [127:0] row_bot,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic         lcd_en,
  output logic [7:0]   lcd_data,
  output logic         busy,
  output logic         frame_done
);

  localparam int unsigned MaxA   = (POWERUP_CYC > E_PULSE_CYC) ? POWERUP_CYC : E_PULSE_CYC;
  localparam int unsigned MaxB   = (CMD_CYC > CLEAR_CYC) ? CMD_CYC : CLEAR_CYC;
  localparam int unsigned MaxCyc = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned CntW   = $clog2(MaxCyc) + 1;

  localparam logic [CntW-1:0] PwrupLast = CntW'(POWERUP_CYC - 1);
  localparam logic [CntW-1:0] PulseLast = CntW'(E_PULSE_CYC - 1);
  localparam logic [CntW-1:0] CmdLast   = CntW'(CMD_CYC - 1);
  localparam logic [CntW-1:0] ClearLast = CntW'(CLEAR_CYC - 1);

  typedef enum logic [1:0] {StPwrup, StInit, StFrame, StIdle} state_e;
  typedef enum logic [2:0] {PhSetup, PhPulse, PhWait, PhSkip, PhDone} phase_e;

  state_e          r_state;
  phase_e          r_phase;
  logic [CntW-1:0] r_cnt;
  logic [5:0]      r_idx;
  logic [127:0]    r_snap_top;
  logic [127:0]    r_snap_bot;

  logic [5:0]      w_next_idx;
  logic [7:0]      w_next_byte;
  logic            w_next_rs;
  logic            w_last_byte;
  logic [CntW-1:0] w_wait_last;
  logic [3:0]      w_col;
  logic [127:0]    w_top_sh;
  logic [127:0]    w_bot_sh;
  logic            w_enter;

  assign lcd_rw      = 1'b0;
  assign w_next_idx  = r_idx + 6'd1;
  // Only the clear command (rs=0) gets the long wait; character 8'h01 does not.
  assign w_wait_last = (!lcd_rs && lcd_data == 8'h01) ? ClearLast : CmdLast;
  assign w_last_byte = (r_state == StInit) ? (r_idx == 6'd3) : (r_idx == 6'd33);
  assign w_col       = (w_next_idx < 6'd17) ? 4'(w_next_idx - 6'd1) : 4'(w_next_idx - 6'd18);
  // Shifting column c to the top byte avoids a variable part-select.
  assign w_top_sh    = r_snap_top << {w_col, 3'b000};
  assign w_bot_sh    = r_snap_bot << {w_col, 3'b000};

  always_comb begin
    w_next_byte = 8'h00;
    w_next_rs   = 1'b0;
    if (r_state == StInit) begin
      case (w_next_idx[1:0])
        2'd1:    w_next_byte = 8'h0C;
        2'd2:    w_next_byte = 8'h06;
        default: w_next_byte = 8'h01;
      endcase
    end else if (w_next_idx == 6'd17) begin
      w_next_byte = 8'hC0;
    end else if (w_next_idx < 6'd17) begin
      w_next_rs   = 1'b1;
      w_next_byte = w_top_sh[127:120];
    end else begin
      w_next_rs   = 1'b1;
      w_next_byte = w_bot_sh[127:120];
    end
  end

  assign w_enter = en && ((r_state == StIdle) ||
                          (r_state == StFrame && r_phase == PhDone) ||
                          (r_state == StInit && r_phase == PhWait &&
                           r_cnt == w_wait_last && w_last_byte));

`ifdef T06_LCD_SKIP_SAME_EN
  logic r_first;
  logic w_same;
  assign w_same = (row_top == r_snap_top) && (row_bot == r_snap_bot);
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state    <= StPwrup;
      r_phase    <= PhSetup;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_snap_top <= '0;
      r_snap_bot <= '0;
      lcd_rs     <= 1'b0;
      lcd_en     <= 1'b0;
      lcd_data   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef T06_LCD_SKIP_SAME_EN
      r_first    <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (r_state)
        StPwrup: begin
          busy  <= 1'b1;
          r_cnt <= r_cnt + CntW'(1);
          if (r_cnt == PwrupLast) begin
            r_state  <= StInit;
            r_phase  <= PhSetup;
            r_cnt    <= '0;
            r_idx    <= '0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h38;
`ifdef T06_LCD_SKIP_SAME_EN
            r_first  <= 1'b1;
`endif
          end
        end
        StInit, StFrame: begin
          case (r_phase)
            PhSetup: begin
              lcd_en  <= 1'b1;
              r_phase <= PhPulse;
              r_cnt   <= '0;
            end
            PhPulse: begin
              r_cnt <= r_cnt + CntW'(1);
              if (r_cnt == PulseLast) begin
                lcd_en  <= 1'b0;
                r_phase <= PhWait;
                r_cnt   <= '0;
              end
            end
            PhWait: begin
              r_cnt <= r_cnt + CntW'(1);
              if (r_cnt == w_wait_last) begin
                r_cnt <= '0;
                if (!w_last_byte) begin
                  r_idx    <= w_next_idx;
                  lcd_rs   <= w_next_rs;
                  lcd_data <= w_next_byte;
                  r_phase  <= PhSetup;
                end else if (r_state == StInit) begin
                  r_state <= StIdle;
                  busy    <= 1'b0;
                end else begin
                  r_phase    <= PhDone;
                  frame_done <= 1'b1;
                end
              end
            end
            PhSkip: begin
              r_phase    <= PhDone;
              frame_done <= 1'b1;
            end
            PhDone: begin
              r_state <= StIdle;
              busy    <= 1'b0;
            end
            default: r_phase <= PhSetup;
          endcase
        end
        default: ;
      endcase

      // Frame entry overrides the fall-through to IDLE chosen above.
      if (w_enter) begin
        r_state    <= StFrame;
        busy       <= 1'b1;
        r_cnt      <= '0;
        r_idx      <= '0;
        r_snap_top <= row_top;
        r_snap_bot <= row_bot;
`ifdef T06_LCD_SKIP_SAME_EN
        r_first    <= 1'b0;
        if (!r_first && w_same) begin
          r_phase <= PhSkip;
        end else begin
          r_phase  <= PhSetup;
          lcd_rs   <= 1'b0;
          lcd_data <= 8'h80;
        end
`else
        r_phase    <= PhSetup;
        lcd_rs     <= 1'b0;
        lcd_data   <= 8'h80;
`endif
      end
    end
  end

endmodule

// File: tb/tb_t06_lcd_refresh_ctrl.sv
// Self-checking bench for t06_lcd_refresh_ctrl: expected bus waveforms are built from byte lists
// and the fixed setup/strobe/wait timing rule.
`timescale 1ns/1ps
module tb_t06_lcd_refresh_ctrl;

  localparam int PwrCyc = 4;
  localparam int EPul   = 2;
  localparam int CmdCyc = 3;
  localparam int ClrCyc = 6;

  logic         clk = 1'b0;
  logic         nrst;
  logic         en;
  logic [127:0] row_top;
  logic [127:0] row_bot;
  logic         lcd_rs;
  logic         lcd_rw;
  logic         lcd_en;
  logic [7:0]   lcd_data;
  logic         busy;
  logic         frame_done;

  int           n_cmp = 0;
  int           n_err = 0;
  logic [8:0]   bq[$];
  logic [8:0]   last_b;

  always #5 clk = ~clk;

  t06_lcd_refresh_ctrl #(
    .POWERUP_CYC (PwrCyc),
    .E_PULSE_CYC (EPul),
    .CMD_CYC     (CmdCyc),
    .CLEAR_CYC   (ClrCyc)
  ) u_dut (
    .clk        (clk),
    .nrst       (nrst),
    .en         (en),
    .row_top    (row_top),
    .row_bot    (row_bot),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_en     (lcd_en),
    .lcd_data   (lcd_data),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {busy, lcd_en, frame_done, lcd_rw, lcd_rs, lcd_data}
  function automatic logic [31:0] obs_vec();
    return 32'({busy, lcd_en, frame_done, lcd_rw, lcd_rs, lcd_data});
  endfunction

  function automatic logic [31:0] exp_vec(input logic b, input logic e, input logic fd,
                                          input logic [8:0] rb);
    return 32'({b, e, fd, 1'b0, rb});
  endfunction

  function automatic logic [127:0] rand_row();
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = 8'($urandom_range(32'h20, 32'h7e));
    return r;
  endfunction

  task automatic load_frame(input logic [127:0] t, input logic [127:0] b);
    bq.delete();
    bq.push_back({1'b0, 8'h80});
    for (int c = 0; c < 16; c++) bq.push_back({1'b1, t[127-8*c -: 8]});
    bq.push_back({1'b0, 8'hC0});
    for (int c = 0; c < 16; c++) bq.push_back({1'b1, b[127-8*c -: 8]});
  endtask

  // act_kind: 1 = replace row_top, 2 = drop en, at the setup cycle of byte act_idx.
  task automatic run_bytes(input string tag, input int act_idx, input int act_kind,
                           output int cycles);
    int w;
    cycles = 0;
    for (int i = 0; i < bq.size(); i++) begin
      w = (bq[i] == 9'h001) ? ClrCyc : CmdCyc;
      tick();
      cycles++;
      check({tag, "_setup"}, obs_vec(), exp_vec(1'b1, 1'b0, 1'b0, bq[i]));
      if (i == act_idx) begin
        if (act_kind == 1) row_top = rand_row();
        else if (act_kind == 2) en = 1'b0;
      end
      for (int k = 0; k < EPul; k++) begin
        tick();
        cycles++;
        check({tag, "_strobe"}, obs_vec(), exp_vec(1'b1, 1'b1, 1'b0, bq[i]));
      end
      for (int k = 0; k < w; k++) begin
        tick();
        cycles++;
        check({tag, "_wait"}, obs_vec(), exp_vec(1'b1, 1'b0, 1'b0, bq[i]));
      end
      last_b = bq[i];
    end
  endtask

  // Entered in the first cycle after nrst rises.
  task automatic powerup_init(input string tag);
    int cyc;
    check({tag, "_pwrup0"}, obs_vec(), exp_vec(1'b0, 1'b0, 1'b0, 9'h000));
    for (int k = 1; k < PwrCyc; k++) begin
      tick();
      check({tag, "_pwrup"}, obs_vec(), exp_vec(1'b1, 1'b0, 1'b0, 9'h000));
    end
    bq = {9'h038, 9'h00C, 9'h006, 9'h001};
    run_bytes({tag, "_init"}, -1, 0, cyc);
    check({tag, "_init_len"}, 32'(cyc), 32'(3 * (1 + EPul + CmdCyc) + (1 + EPul + ClrCyc)));
  endtask

  task automatic check_idle(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      check(tag, obs_vec(), exp_vec(1'b0, 1'b0, 1'b0, last_b));
    end
  endtask

  task automatic check_done(input string tag);
    tick();
    check(tag, obs_vec(), exp_vec(1'b1, 1'b0, 1'b1, last_b));
  endtask

  initial begin
    int           cyc;
    logic [127:0] s_top;
    logic [127:0] s_bot;

    nrst    = 1'b0;
    en      = 1'b0;
    row_top = rand_row();
    row_bot = rand_row();
    tick();
    tick();
    check("reset_state", obs_vec(), exp_vec(1'b0, 1'b0, 1'b0, 9'h000));

    // Power-up and init with en=0, then IDLE.
    nrst = 1'b1;
    powerup_init("boot");
    check_idle("boot_idle", 3);

    // "RUN" frame timing.
    en      = 1'b1;
    row_top = {"RUN", {13{8'h20}}};
    row_bot = {16{8'h20}};
    load_frame(row_top, row_bot);
    run_bytes("run", -1, 0, cyc);
    check("run_len", 32'(cyc), 32'd204);
    check_done("run_done");

    // Row change mid-frame must not tear.
    row_top = rand_row();
    row_bot = rand_row();
    load_frame(row_top, row_bot);
    run_bytes("tear", 5, 1, cyc);
    check_done("tear_done");

    // New text appears next frame; en dropped at byte 10 still completes.
    load_frame(row_top, row_bot);
    run_bytes("stop", 10, 2, cyc);
    check_done("stop_done");
    check_idle("stop_idle", 5);

    // Reset mid-strobe.
    en = 1'b1;
    tick();
    check("rst_setup", obs_vec(), exp_vec(1'b1, 1'b0, 1'b0, 9'h080));
    tick();
    check("rst_strobe", obs_vec(), exp_vec(1'b1, 1'b1, 1'b0, 9'h080));
    #2;
    nrst = 1'b0;
    #1;
    check("rst_async_en", 32'(lcd_en), 32'd0);
    check("rst_async_all", obs_vec(), exp_vec(1'b0, 1'b0, 1'b0, 9'h000));
    en = 1'b0;
    tick();
    tick();
    nrst = 1'b1;
    powerup_init("reboot");
    check_idle("reboot_idle", 2);

    // Constant rows with en=1: first frame always sent.
    en    = 1'b1;
    s_top = rand_row();
    s_bot = rand_row();
    row_top = s_top;
    row_bot = s_bot;
    load_frame(s_top, s_bot);
    run_bytes("const1", -1, 0, cyc);
    check_done("const1_done");
`ifdef T06_LCD_SKIP_SAME_EN
    for (int f = 0; f < 3; f++) begin
      tick();
      check("skip_start", obs_vec(), exp_vec(1'b1, 1'b0, 1'b0, last_b));
      tick();
      check("skip_done", obs_vec(), exp_vec(1'b1, 1'b0, 1'b1, last_b));
    end
`else
    run_bytes("const2", -1, 0, cyc);
    check("const2_len", 32'(cyc), 32'd204);
    check_done("const2_done");
`endif
    do row_bot = rand_row(); while (row_bot == s_bot);
    load_frame(row_top, row_bot);
    run_bytes("changed", -1, 0, cyc);
    check_done("changed_done");
    en = 1'b0;
    check_idle("final_idle", 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
